// File: rtl/regfile_wb_queue_pkg.sv
// regfile_wb_queue_pkg: shared types for the writeback queue.
// REGFILE_WB_FWD_EN (in the top) enables the decode bypass ports.
package regfile_wb_queue_pkg;
    localparam int WB_XLEN = 32;
    typedef logic [4:0] reg_idx_t;
    typedef struct packed {
        reg_idx_t           rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_queue_wb_match_scan.sv
// wb_match_scan: finds the youngest valid queue entry whose rd equals rs.
// The scan walks back from tail-1 toward head; rs==0 never matches.
module wb_match_scan
    import regfile_wb_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  reg_idx_t      rs,
    input  logic [AW-1:0] tail,
    input  logic [AW:0]   count,
    input  reg_idx_t      rd [DEPTH],
    output logic          hit,
    output logic [AW-1:0] idx
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        // descending loop so the youngest match (i==0) is assigned last
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rs != '0 && (AW+1)'(i) < count && rd[tail - AW'(i + 1)] == rs) begin
                hit = 1'b1;
                idx = tail - AW'(i + 1);
            end
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback queue feeding the register file write port.
// Define REGFILE_WB_FWD_EN to add rsN_fwd_hit / rsN_fwd_data bypass outputs.
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = WB_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  reg_idx_t        alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  reg_idx_t        lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            wb_stall,
    output logic            wb_we,
    output reg_idx_t        wb_rd,
    output logic [XLEN-1:0] wb_wdata,
    input  reg_idx_t        rs1,
    input  reg_idx_t        rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
`ifdef REGFILE_WB_FWD_EN
    output logic            rs1_fwd_hit,
    output logic            rs2_fwd_hit,
    output logic [XLEN-1:0] rs1_fwd_data,
    output logic [XLEN-1:0] rs2_fwd_data,
`endif
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t        ent_q [DEPTH];
    entry_t        push_e;
    reg_idx_t      rd_arr [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, idx1, idx2;
    logic [AW:0]   count_q, count_d;
    logic          q_full, q_empty, push, hit1, hit2;

    assign q_full    = count_q == (AW+1)'(DEPTH);
    assign q_empty   = count_q == '0;
    assign alu_ready = rst_n && !q_full;
    assign lsu_ready = rst_n && !q_full && !alu_valid;
    assign full      = rst_n && q_full;
    assign empty     = !rst_n || q_empty;
    assign push_e    = alu_valid ? {alu_rd, alu_data} : {lsu_rd, lsu_data};
    // rd==0 handshakes complete but are dropped here
    assign push      = ((alu_valid && alu_ready) || (lsu_valid && lsu_ready)) && push_e.rd != '0;
    assign wb_we     = rst_n && !q_empty && !wb_stall;
    assign wb_rd     = ent_q[head_q].rd;
    assign wb_wdata  = ent_q[head_q].data;

    always_comb begin
        head_d  = wb_we ? head_q + AW'(1) : head_q;
        tail_d  = push ? tail_q + AW'(1) : tail_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(wb_we);
        for (int i = 0; i < DEPTH; i++) rd_arr[i] = ent_q[i].rd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) ent_q[tail_q] <= push_e;
    end

    wb_match_scan #(.DEPTH(DEPTH)) u_scan1 (
        .rs(rs1), .tail(tail_q), .count(count_q), .rd(rd_arr), .hit(hit1), .idx(idx1)
    );
    wb_match_scan #(.DEPTH(DEPTH)) u_scan2 (
        .rs(rs2), .tail(tail_q), .count(count_q), .rd(rd_arr), .hit(hit2), .idx(idx2)
    );

    assign rs1_busy = rst_n && hit1;
    assign rs2_busy = rst_n && hit2;

`ifdef REGFILE_WB_FWD_EN
    assign rs1_fwd_hit  = rs1_busy;
    assign rs2_fwd_hit  = rs2_busy;
    assign rs1_fwd_data = rs1_busy ? ent_q[idx1].data : '0;
    assign rs2_fwd_data = rs2_busy ? ent_q[idx2].data : '0;
`else
    logic unused_idx;
    assign unused_idx = ^{idx1, idx2};
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed stimulus with a write scoreboard checked by a monitor.
// Build with REGFILE_WB_FWD_EN to also check the bypass outputs.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n, alu_valid, lsu_valid, wb_stall;
    logic            alu_ready, lsu_ready, wb_we, rs1_busy, rs2_busy, full, empty;
    logic [4:0]      alu_rd, lsu_rd, rs1, rs2, wb_rd;
    logic [XLEN-1:0] alu_data, lsu_data, wb_wdata;
`ifdef REGFILE_WB_FWD_EN
    logic            rs1_fwd_hit, rs2_fwd_hit;
    logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

    int errors = 0;
    int checks = 0;
    int writes = 0;
    logic [4+XLEN:0] sb [$];

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_stall(wb_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef REGFILE_WB_FWD_EN
        .rs1_fwd_hit(rs1_fwd_hit), .rs2_fwd_hit(rs2_fwd_hit),
        .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
        .full(full), .empty(empty)
    );

    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            logic [4+XLEN:0] exp_w;
            checks++;
            writes++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_write unexpected rd=%0d data=%h", wb_rd, wb_wdata);
            end else begin
                exp_w = sb.pop_front();
                if ({wb_rd, wb_wdata} !== exp_w) begin
                    errors++;
                    $display("FAIL wb_write got rd=%0d data=%h expected rd=%0d data=%h",
                             wb_rd, wb_wdata, exp_w[XLEN+4:XLEN], exp_w[XLEN-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [XLEN-1:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    initial begin
        rst_n = 1'b0; wb_stall = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = '0;
        rs1 = 5'd5; rs2 = 5'd0;
        drive_alu(5'd5, 32'h1);
        @(negedge clk);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", rs1_busy, 0);
        step();
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0; rst_n = 1'b1;

        // single ALU push, one-cycle latency
        drive_alu(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_alu_ready", alu_ready, 1);
        sb.push_back({5'd5, 32'hDEADBEEF});
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t1_wb_we", wb_we, 1);
        chk("t1_busy_head", rs1_busy, 1);
        step();
        @(negedge clk);
        chk("t1_empty", empty, 1);
        chk("t1_wb_we_off", wb_we, 0);

        // arbitration: ALU wins, LSU follows
        step();
        drive_alu(5'd3, 32'h33);
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        @(negedge clk);
        chk("t2_alu_ready", alu_ready, 1);
        chk("t2_lsu_blocked", lsu_ready, 0);
        sb.push_back({5'd3, 32'h33});
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t2_lsu_ready", lsu_ready, 1);
        sb.push_back({5'd4, 32'h44});
        step();
        lsu_valid = 1'b0;
        repeat (3) step();

        // stall fills the queue
        wb_stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive_alu(5'(10 + i), 32'hA0 + 32'(i));
            @(negedge clk);
            chk("t3_fill_ready", alu_ready, 1);
            sb.push_back({5'(10 + i), 32'hA0 + 32'(i)});
            step();
        end
        drive_alu(5'd20, 32'hBAD);
        rs1 = 5'd12; rs2 = 5'd9;
        @(negedge clk);
        chk("t3_full", full, 1);
        chk("t3_alu_ready_full", alu_ready, 0);
        chk("t3_lsu_ready_full", lsu_ready, 0);
        chk("t3_stalled_we", wb_we, 0);
        chk("t3_not_empty", empty, 0);
        chk("t3_busy_mid", rs1_busy, 1);
        chk("t3_busy_miss", rs2_busy, 0);
        step();
        wb_stall = 1'b0;
        drive_alu(5'd21, 32'hBAD);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == 0) chk("t3_full_pop_no_push", alu_ready, 0);
            chk("t3_drain_we", wb_we, 1);
            step();
            alu_valid = 1'b0;
        end
        @(negedge clk);
        chk("t3_drained_empty", empty, 1);
        chk("t3_drained_full", full, 0);

        // rd==0 is accepted and dropped
        step();
        drive_alu(5'd0, 32'h1);
        @(negedge clk);
        chk("t4_rd0_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t4_rd0_empty", empty, 1);
        chk("t4_rd0_no_we", wb_we, 0);

        // busy on repeated rd, youngest forwarded
        step();
        wb_stall = 1'b1;
        rs1 = 5'd7; rs2 = 5'd0;
        drive_alu(5'd7, 32'h11);
        @(negedge clk);
        chk("t5_busy_excl_push", rs1_busy, 0);
        sb.push_back({5'd7, 32'h11});
        step();
        drive_alu(5'd7, 32'h22);
        @(negedge clk);
        chk("t5_busy_one", rs1_busy, 1);
`ifdef REGFILE_WB_FWD_EN
        chk("t5_fwd_old", rs1_fwd_data, 32'h11);
`endif
        sb.push_back({5'd7, 32'h22});
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t5_busy_two", rs1_busy, 1);
        chk("t5_rs0_busy", rs2_busy, 0);
`ifdef REGFILE_WB_FWD_EN
        chk("t5_fwd_hit", rs1_fwd_hit, 1);
        chk("t5_fwd_young", rs1_fwd_data, 32'h22);
        chk("t5_fwd_rs0", rs2_fwd_data, 0);
`endif
        step();
        wb_stall = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("t5_busy_clear", rs1_busy, 0);

        // reset discards queued entries
        step();
        wb_stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_alu(5'(i), 32'hC0 + 32'(i));
            step();
        end
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t6_busy_pre", rs1_busy, 0);
        step();
        rst_n = 1'b0; wb_stall = 1'b0;
        rs1 = 5'd2;
        drive_alu(5'd9, 32'h9);
        @(negedge clk);
        chk("t6_rst_we", wb_we, 0);
        chk("t6_rst_ready", alu_ready, 0);
        chk("t6_rst_busy", rs1_busy, 0);
        step();
        @(negedge clk);
        chk("t6_rst_empty", empty, 1);
        step();
        rst_n = 1'b1; alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_post_we", wb_we, 0);
            chk("t6_post_empty", empty, 1);
            step();
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        chk("sb_drained", 64'(sb.size()), 0);
        chk("write_count", 64'(writes), 9);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
